// File: rtl/nor_bus_pg.sv
// nor_bus_pg: Wishbone-pipelined to parallel NOR flash bridge. Requests are
// queued, then run through the IDLE/RYWAIT/WRITE/READ/PAGE/END sequencer.
// Ports: wb_* pipelined Wishbone slave (ack/err pulses, stall = queue full);
// cfg_pgmode_i enables page-mode reads; nor_ry_i device ready; nor_* pads
// with active-low ce/we/oe and nor_data_oe = 1 when driving data pads.
module nor_bus_pg #(
  parameter int ADDRBITS    = 26,
  parameter int DATABITS    = 16,
  parameter int COUNTERBITS = 8,
  parameter int QDEPTH      = 4,
  parameter int PAGEBITS    = 3,
  parameter int T_WRITE     = 14,
  parameter int T_READ      = 45,
  parameter int T_PAGE      = 7,
  parameter int T_END       = 1,
  parameter int T_RY        = 250
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ADDRBITS-1:0] wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic                wb_stall_o,
  input  logic                cfg_pgmode_i,
  input  logic                nor_ry_i,
  input  logic [DATABITS-1:0] nor_data_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic [ADDRBITS-1:0] nor_addr_o,
  output logic                nor_ce_o,
  output logic                nor_we_o,
  output logic                nor_oe_o,
  output logic                nor_data_oe
);
  localparam int PW = $clog2(QDEPTH);
  localparam int EW = 1 + DATABITS + ADDRBITS;
  localparam int CW = COUNTERBITS;
  localparam logic [CW-1:0] TWR = CW'(T_WRITE);
  localparam logic [CW-1:0] TRD = CW'(T_READ);
  localparam logic [CW-1:0] TPG = CW'(T_PAGE);
  localparam logic [CW-1:0] TEN = CW'(T_END);
  localparam logic [CW-1:0] TRY = CW'(T_RY);
  localparam logic [PW:0]   QFULL = (PW+1)'(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RYWAIT, S_WRITE, S_READ, S_PAGE, S_END
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, rp_nx;
  logic [PW:0] qcnt_q, qcnt_d;
  logic [EW-1:0] mem_q [QDEPTH];
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic [DATABITS-1:0] rdat_q, rdat_d;
  logic ack_q, ack_d, err_q, err_d;
  logic ce_q, ce_d, we_q, we_d, oe_q, oe_d;
  logic doe_q, doe_d, pgm_q, pgm_d;

  logic push, pop, full;
  logic head_v, head_we, nxt_v, nxt_we;
  logic [ADDRBITS-1:0] head_adr, nxt_adr;
  logic [DATABITS-1:0] head_dat;
  logic restart, load, load_nxt, rd_last, same_pg;

  assign rp_nx    = rp_q + 1'b1;
  assign head_v   = |qcnt_q;
  assign nxt_v    = |qcnt_q[PW:1];
  assign head_we  = mem_q[rp_q][EW-1];
  assign head_dat = mem_q[rp_q][ADDRBITS +: DATABITS];
  assign head_adr = mem_q[rp_q][ADDRBITS-1:0];
  assign nxt_we   = mem_q[rp_nx][EW-1];
  assign nxt_adr  = mem_q[rp_nx][ADDRBITS-1:0];
  assign same_pg  = nxt_adr[ADDRBITS-1:PAGEBITS]
                 == addr_q[ADDRBITS-1:PAGEBITS];
  assign rd_last  = cnt_q == ((state_q == S_PAGE) ? TPG : TRD);

  assign full       = qcnt_q == QFULL;
  assign pop        = ack_d | err_d;
  // A slot freed on this edge can be refilled on the same edge.
  assign wb_stall_o = full & ~pop;
  assign push       = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  always_comb begin
    state_d  = state_q;
    restart  = 1'b0;
    load     = 1'b0;
    load_nxt = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = rdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && head_v) begin
          restart = 1'b1;
          if (nor_ry_i) begin
            load    = 1'b1;
            state_d = head_we ? S_WRITE : S_READ;
          end else begin
            state_d = S_RYWAIT;
          end
        end
      end
      S_RYWAIT: begin
        if (!wb_cyc_i) begin
          restart = 1'b1;
          state_d = S_IDLE;
        end else if (nor_ry_i) begin
          restart = 1'b1;
          load    = 1'b1;
          state_d = head_we ? S_WRITE : S_READ;
        end else if (cnt_q == TRY) begin
          restart = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (!wb_cyc_i || cnt_q == TWR) begin
          restart = 1'b1;
          ack_d   = wb_cyc_i;
          state_d = S_END;
        end
      end
      S_READ, S_PAGE: begin
        if (!wb_cyc_i) begin
          restart = 1'b1;
          state_d = S_END;
        end else if (rd_last) begin
          restart = 1'b1;
          ack_d   = 1'b1;
          rdat_d  = nor_data_i;
          // Stay in page mode only for a queued read in the same page.
          if (pgm_q && nxt_v && !nxt_we && same_pg) begin
            load_nxt = 1'b1;
            state_d  = S_PAGE;
          end else begin
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (cnt_q == TEN) begin
          restart = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        restart = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d  = restart ? '0 : cnt_q + 1'b1;
    pgm_d  = (state_q == S_IDLE) ? cfg_pgmode_i : pgm_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    qcnt_d = qcnt_q;
    if (!wb_cyc_i) begin
      wp_d   = '0;
      rp_d   = '0;
      qcnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop) rp_d = rp_nx;
      if (push && !pop) qcnt_d = qcnt_q + 1'b1;
      else if (pop && !push) qcnt_d = qcnt_q - 1'b1;
    end
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      addr_d = head_adr;
      data_d = head_dat;
    end else if (load_nxt) begin
      addr_d = nxt_adr;
    end
    // Strobes decode the next state so they are valid for its whole span.
    ce_d  = !(state_d == S_WRITE || state_d == S_READ
              || state_d == S_PAGE);
    we_d  = state_d != S_WRITE;
    oe_d  = !(state_d == S_READ || state_d == S_PAGE);
    doe_d = (state_d == S_WRITE)
         || (state_d == S_END && (state_q == S_WRITE || doe_q));
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wp_q] <= {wb_we_i, wb_dat_i, wb_adr_i};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      qcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      doe_q   <= 1'b0;
      pgm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      qcnt_q  <= qcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      doe_q   <= doe_d;
      pgm_q   <= pgm_d;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_dat_o    = rdat_q;
  assign nor_addr_o  = addr_q;
  assign nor_data_o  = data_q;
  assign nor_ce_o    = ce_q;
  assign nor_we_o    = we_q;
  assign nor_oe_o    = oe_q;
  assign nor_data_oe = doe_q;
endmodule

// File: tb/tb_nor_bus_pg.sv
// tb_nor_bus_pg: directed bench for nor_bus_pg; stimulus queues expected
// responses, a monitor pops and compares them whenever ack/err appears.
module tb_nor_bus_pg;
  logic clk = 1'b0;
  logic rst, cyc, stb, we, pgm, ry;
  logic [25:0] adr;
  logic [15:0] dat;
  logic ack, err, stall;
  logic [15:0] dat_o, nd_o, nd_i;
  logic [25:0] na;
  logic ce, nwe, oe, doe;

  int n_chk = 0;
  int n_fail = 0;
  int n_resp = 0;
  int cyc_n = 0;
  int we_lo = 0, oe_lo = 0, ce_lo = 0, doe_hi = 0, ce_rise = 0;
  int b_we, b_oe, b_ce, b_doe, b_rise;
  logic ce_prev = 1'b1;

  typedef struct {
    bit err;
    bit dchk;
    logic [15:0] dat;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [15:0] model(input logic [25:0] a);
    case (a)
      26'h10:  return 16'hA5A5;
      26'h11:  return 16'h5A5A;
      26'h12:  return 16'h1234;
      26'h13:  return 16'hC3C3;
      default: return a[15:0] ^ 16'hFFFF;
    endcase
  endfunction

  always_comb nd_i = model(na);

  nor_bus_pg dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_we_i(we),
    .wb_stb_i(stb), .wb_cyc_i(cyc),
    .wb_ack_o(ack), .wb_err_o(err),
    .wb_dat_o(dat_o), .wb_stall_o(stall),
    .cfg_pgmode_i(pgm), .nor_ry_i(ry),
    .nor_data_i(nd_i), .nor_data_o(nd_o),
    .nor_addr_o(na), .nor_ce_o(ce),
    .nor_we_o(nwe), .nor_oe_o(oe),
    .nor_data_oe(doe)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic sb_add(input bit e, input bit dc,
                        input logic [15:0] d, input int c);
    exp_t x;
    x.err = e;
    x.dchk = dc;
    x.dat = d;
    x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic snap();
    b_we = we_lo;
    b_oe = oe_lo;
    b_ce = ce_lo;
    b_doe = doe_hi;
    b_rise = ce_rise;
  endtask

  task automatic push(input logic w, input logic [25:0] a,
                      input logic [15:0] d, output int p);
    logic s;
    int k;
    k = 0;
    @(negedge clk);
    cyc = 1'b1;
    stb = 1'b1;
    we = w;
    adr = a;
    dat = d;
    forever begin
      #1 s = stall;
      @(posedge clk);
      if (!s || k > 2000) break;
      k++;
      @(negedge clk);
    end
    #1 p = cyc_n;
    chk("push_accept", 32'(s), 32'd0);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("drain_outstanding", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_ce"}, 32'(ce), 32'd1);
    chk({tag, "_we"}, 32'(nwe), 32'd1);
    chk({tag, "_oe"}, 32'(oe), 32'd1);
    chk({tag, "_doe"}, 32'(doe), 32'd0);
    chk({tag, "_addr"}, 32'(na), 32'd0);
    chk({tag, "_wdata"}, 32'(nd_o), 32'd0);
    chk({tag, "_rdata"}, 32'(dat_o), 32'd0);
    chk({tag, "_ack_err"}, 32'({ack, err}), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (ack || err) begin
        n_resp++;
        chk("ack_err_excl", 32'(ack & err), 32'd0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: ack=%0b err=%0b cycle=%0d, none required",
                   ack, err, cyc_n);
        end else begin
          x = sb.pop_front();
          chk("rsp_kind_err", 32'(err), 32'(x.err));
          if (x.dchk) chk("rd_data", 32'(dat_o), 32'(x.dat));
          if (x.cyc >= 0) chk("rsp_cycle", cyc_n, x.cyc);
        end
      end
      if (!nwe) we_lo++;
      if (!oe) oe_lo++;
      if (!ce) ce_lo++;
      if (doe) doe_hi++;
      if (ce && !ce_prev) ce_rise++;
      ce_prev = ce;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int p, p0, p1, p2, p3, p4, p5, r0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat = '0; pgm = 1'b0; ry = 1'b1;
    repeat (3) @(negedge clk);
    chk_rst_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single write
    snap();
    push(1'b1, 26'h123, 16'hBEEF, p);
    sb_add(1'b0, 1'b0, 16'h0, p + 16);
    idle_bus();
    drain(200);
    chk("wr_addr", 32'(na), 32'h123);
    chk("wr_data", 32'(nd_o), 32'hBEEF);
    repeat (5) @(negedge clk);
    chk("wr_we_low", we_lo - b_we, 32'd15);
    chk("wr_ce_low", ce_lo - b_ce, 32'd15);
    chk("wr_doe_hi", doe_hi - b_doe, 32'd17);
    chk("wr_oe_low", oe_lo - b_oe, 32'd0);

    // single read
    snap();
    push(1'b0, 26'h10, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'hA5A5, p + 47);
    idle_bus();
    drain(300);
    repeat (4) @(negedge clk);
    chk("rd_oe_low", oe_lo - b_oe, 32'd46);
    chk("rd_we_low", we_lo - b_we, 32'd0);
    chk("rd_doe_hi", doe_hi - b_doe, 32'd0);

    // page-mode burst
    pgm = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    push(1'b0, 26'h10, 16'h0, p0);
    sb_add(1'b0, 1'b1, 16'hA5A5, p0 + 47);
    push(1'b0, 26'h11, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'h5A5A, p0 + 55);
    push(1'b0, 26'h12, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'h1234, p0 + 63);
    push(1'b0, 26'h13, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'hC3C3, p0 + 71);
    idle_bus();
    drain(400);
    repeat (4) @(negedge clk);
    chk("pg_ce_rise", ce_rise - b_rise, 32'd1);
    chk("pg_ce_low", ce_lo - b_ce, 32'd70);

    // same reads, page mode off
    pgm = 1'b0;
    repeat (2) @(negedge clk);
    snap();
    push(1'b0, 26'h10, 16'h0, p0);
    sb_add(1'b0, 1'b1, 16'hA5A5, p0 + 47);
    push(1'b0, 26'h11, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'h5A5A, p0 + 96);
    push(1'b0, 26'h12, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'h1234, p0 + 145);
    push(1'b0, 26'h13, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'hC3C3, p0 + 194);
    idle_bus();
    drain(600);
    repeat (4) @(negedge clk);
    chk("npg_ce_rise", ce_rise - b_rise, 32'd4);

    // six requests into a 4-deep queue
    push(1'b0, 26'h20, 16'h0, p0);
    sb_add(1'b0, 1'b1, 16'hFFDF, p0 + 47);
    push(1'b1, 26'h30, 16'h1111, p1);
    sb_add(1'b0, 1'b0, 16'h0, p0 + 65);
    push(1'b0, 26'h21, 16'h0, p2);
    sb_add(1'b0, 1'b1, 16'hFFDE, -1);
    push(1'b0, 26'h22, 16'h0, p3);
    sb_add(1'b0, 1'b1, 16'hFFDD, -1);
    push(1'b0, 26'h23, 16'h0, p4);
    sb_add(1'b0, 1'b1, 16'hFFDC, -1);
    push(1'b0, 26'h24, 16'h0, p5);
    sb_add(1'b0, 1'b1, 16'hFFDB, -1);
    idle_bus();
    chk("q_push4_edge", p3 - p0, 32'd3);
    chk("q_push5_edge", p4 - p0, 32'd47);
    chk("q_push6_edge", p5 - p0, 32'd65);
    drain(1000);

    // ready timeout
    ry = 1'b0;
    snap();
    push(1'b0, 26'h40, 16'h0, p);
    sb_add(1'b1, 1'b0, 16'h0, p + 252);
    idle_bus();
    drain(400);
    chk("ry_ce_low", ce_lo - b_ce, 32'd0);
    @(negedge clk);
    ry = 1'b1;
    push(1'b0, 26'h11, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'h5A5A, p + 47);
    idle_bus();
    drain(300);

    // ready arrives during RYWAIT
    ry = 1'b0;
    push(1'b0, 26'h12, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'h1234, p + 57);
    idle_bus();
    repeat (10) @(negedge clk);
    ry = 1'b1;
    drain(300);

    // abort mid-read with entries queued
    push(1'b0, 26'h50, 16'h0, p);
    push(1'b0, 26'h51, 16'h0, p);
    push(1'b0, 26'h52, 16'h0, p);
    idle_bus();
    repeat (20) @(negedge clk);
    chk("abort_pre_oe", 32'(oe), 32'd0);
    cyc = 1'b0;
    r0 = n_resp;
    @(negedge clk);
    chk("abort_ce", 32'(ce), 32'd1);
    chk("abort_oe", 32'(oe), 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_no_rsp", n_resp - r0, 32'd0);
    push(1'b0, 26'h13, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'hC3C3, p + 47);
    idle_bus();
    drain(300);

    // async reset mid-write
    push(1'b1, 26'h200, 16'h5555, p);
    idle_bus();
    repeat (5) @(negedge clk);
    chk("rst_pre_we", 32'(nwe), 32'd0);
    #2 rst = 1'b1;
    cyc = 1'b0;
    #1 chk_rst_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push(1'b0, 26'h10, 16'h0, p);
    sb_add(1'b0, 1'b1, 16'hA5A5, p + 47);
    idle_bus();
    drain(300);

    cyc = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nor_bus_pg.md
# nor_bus_pg

Parametrised Wishbone-pipelined to parallel NOR flash bridge: the second-generation bus master for the NR1B NOR array. Requests are buffered in a configurable-depth queue. Successive reads within the same flash page are served as page-mode reads with CE#/OE# held low. Each access waits on the device RY/BY# line, and a ready timeout returns `wb_err_o`. It sits between the Wishbone interconnect and the NOR pads.

## Interface
- `ADDRBITS`, 26, word address width.
- `DATABITS`, 16, data width.
- `COUNTERBITS`, 8, wait/timeout counter width; every `T_*` must be < 2^COUNTERBITS.
- `QDEPTH`, 4, request queue depth; power of two, ≥2.
- `PAGEBITS`, 3, low address bits within a page (8-word pages).
- `T_WRITE`, 14; `T_READ`, 45; `T_PAGE`, 7; `T_END`, 1; `T_RY`, 250: state hold counts (state lasts T+1 clocks).
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wb_adr_i` in ADDRBITS, `wb_dat_i` in DATABITS, `wb_we_i` in 1, `wb_stb_i` in 1, `wb_cyc_i` in 1: Wishbone pipelined request.
- `wb_ack_o` out 1, `wb_err_o` out 1, `wb_dat_o` out DATABITS, `wb_stall_o` out 1: Wishbone response.
- `cfg_pgmode_i` in 1: 1 enables page-mode reads; sample only in IDLE.
- `nor_ry_i` in 1: device ready (1 = ready).
- `nor_data_i` in DATABITS, `nor_data_o` out DATABITS, `nor_addr_o` out ADDRBITS.
- `nor_ce_o` out 1, `nor_we_o` out 1, `nor_oe_o` out 1: active-low strobes.
- `nor_data_oe` out 1: pad direction, 1 = drive.

## Operation
- **Queue**
  - Entry = {we, dat, adr}, pushed when `wb_cyc_i && wb_stb_i && !wb_stall_o`.
  - `wb_stall_o` = queue full.
  - Head is popped on the edge that raises `wb_ack_o` or `wb_err_o`.
  - Push and pop in the same cycle are legal when full; stall stays 0 for that slot.
- **States:** IDLE, RYWAIT, WRITE, READ, PAGE, END.
- **IDLE**
  - Head valid and `nor_ry_i`=1 → WRITE or READ by `we`.
  - Head valid and `nor_ry_i`=0 → RYWAIT.
- **RYWAIT**
  - On `nor_ry_i`=1 → WRITE or READ.
  - Counter reaches `T_RY` → pulse `wb_err_o`, pop, go to IDLE.
- **WRITE:** after T_WRITE+1 clocks, ack and go to END.
- **READ / PAGE**
  - On the last clock, sample `nor_data_i` into `wb_dat_o` and ack.
  - Go to PAGE if `cfg_pgmode_i`, the next entry is valid and is a read, and its `adr[ADDRBITS-1:PAGEBITS]` equals the current page. Otherwise go to END.
- **END:** strobes high for T_END+1 clocks, then IDLE.
- **Counter:** clears on every state entry and increments each clock.
- **Outputs:** registered, decoded from next state, so each strobe is valid for the whole state.
  - CE#=0 in WRITE, READ, PAGE.
  - WE#=0 in WRITE.
  - OE#=0 in READ, PAGE.
  - `nor_data_oe`=1 in WRITE and the following END.
  - `nor_addr_o` and `nor_data_o` load from the entry being started; they hold otherwise.
- **Abort**
  - `wb_cyc_i` falling flushes the queue and suppresses any pending ack/err.
  - If mid-access, the FSM goes to END; the write pulse is truncated, and that is the caller's responsibility.
  - No ack is issued while `wb_cyc_i`=0.
- **Reset values**
  - `nor_ce_o`=`nor_we_o`=`nor_oe_o`=1.
  - `nor_data_oe`=0.
  - addr, data, `wb_dat_o` = 0.
  - `wb_ack_o`=`wb_err_o`=0, `wb_stall_o`=0, queue empty, state IDLE.

## Timing
- **First read:** ack 1+(T_READ+1) clocks after the push edge; default 47.
- **Page read:** ack T_PAGE+1 clocks after the previous ack; default 8.
- **Write:** ack 1+(T_WRITE+1) clocks after the push; the next access starts ≥T_END+1 clocks after the ack.
- **Response pulses:** ack and err are single-cycle and never coincide. `wb_dat_o` is valid only with ack.
- **Throughput:** back-to-back page reads give one ack per T_PAGE+1 clocks with CE# continuously low.
- **Reset:** assertion mid-access forces all reset values asynchronously; the FSM resumes from IDLE after release.

## Test plan
- Single write, adr=0x0000123, dat=0xBEEF → WE# low 15 clocks, `nor_data_oe`=1, ack at clock 16, CE# high for 2 clocks.
- Read of 0x10 with the model returning 0xA5A5 → OE# low 46 clocks, ack at 47, `wb_dat_o`=0xA5A5.
- Four pipelined reads 0x10–0x13, `cfg_pgmode_i`=1 → acks at 47, 55, 63, 71, CE# never rises; with `cfg_pgmode_i`=0 there is an END between each access.
- `QDEPTH`=4: push 6 requests back-to-back → stall after 4 and release on the first ack; all 6 acked in order with correct data.
- `nor_ry_i` held 0 → `wb_err_o` after 251 RYWAIT clocks, CE# never low, next request proceeds normally.
- Drop `wb_cyc_i` mid-READ with 2 queued → END, then IDLE, no acks, queue empty; async reset mid-WRITE → all reset values in the same cycle.
